// File: rtl/regfile_wb.sv
// regfile_wb: Y86-64 register file plus SEQ write-back stage.
// Two combinational read ports (srcA/srcB) and two write ports per cycle
// (valE->dstE, valM->dstM). Writes are gated by wb_en, the sticky halted
// flag and the incoming instruction status. An optional write-through
// bypass makes same-cycle writes visible on the read ports.
// wb_en is a plain stall qualifier: when low, nothing commits and stat is
// ignored. There is no ready/back-pressure path from this block.
// The only piece of control state is the sticky halted flag, which is
// exported directly on the halted output.
module regfile_wb #(
  parameter int               WIDTH     = 64,
  parameter int               NREGS     = 15,
  parameter bit               BYPASS    = 1'b1,
  parameter logic [WIDTH-1:0] RSP_RESET = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_en,
  input  logic [1:0]       stat,
  input  logic [3:0]       srcA,
  input  logic [3:0]       srcB,
  input  logic [3:0]       dstE,
  input  logic [3:0]       dstM,
  input  logic [WIDTH-1:0] valE,
  input  logic [WIDTH-1:0] valM,
  output logic [WIDTH-1:0] valA,
  output logic [WIDTH-1:0] valB,
  input  logic [3:0]       dbg_id,
  output logic [WIDTH-1:0] dbg_val,
  output logic [WIDTH-1:0] rsp,
  output logic             halted,
  output logic [15:0]      wr_count
);

  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam int         RSP_ID   = 4;

  logic [WIDTH-1:0] regs [NREGS];

  logic             commit;
  logic             wrE;
  logic             wrM;
  logic [1:0]       nWrites;
  logic [16:0]      countSum;
  logic [WIDTH-1:0] committedA;
  logic [WIDTH-1:0] committedB;

  // A write commits only out of reset, when not stalled, not halted and
  // the instruction status is AOK. Port M wins a same-ID conflict, so port
  // E is dropped entirely in that case and the pair counts as one write.
  assign commit   = rst_n & wb_en & ~halted & (stat == STAT_AOK);
  assign wrM      = commit & (dstM != RNONE);
  assign wrE      = commit & (dstE != RNONE) & (dstE != dstM);
  assign nWrites  = {1'b0, wrE} + {1'b0, wrM};
  assign countSum = {1'b0, wr_count} + {15'd0, nWrites};

  // Register array: reset image, then per-register write select (M over E).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == RSP_ID) ? RSP_RESET : '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wrM && (dstM == 4'(i))) begin
          regs[i] <= valM;
        end else if (wrE && (dstE == 4'(i))) begin
          regs[i] <= valE;
        end
      end
    end
  end

  // Sticky halt: first accepted non-AOK status stops all further writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted <= 1'b0;
    end else if (wb_en && !halted && (stat != STAT_AOK)) begin
      halted <= 1'b1;
    end
  end

  // Committed-write counter, saturating at all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= '0;
    end else if (countSum[16]) begin
      wr_count <= 16'hFFFF;
    end else begin
      wr_count <= countSum[15:0];
    end
  end

  // Committed-state lookups; ID 0xF (and anything past NREGS) reads zero.
  always_comb begin
    committedA = '0;
    committedB = '0;
    dbg_val    = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (srcA == 4'(i)) committedA = regs[i];
      if (srcB == 4'(i)) committedB = regs[i];
      if (dbg_id == 4'(i)) dbg_val = regs[i];
    end
  end

  // Read ports with optional write-through; wrM/wrE already exclude RNONE.
  always_comb begin
    valA = committedA;
    valB = committedB;
    if (BYPASS) begin
      if (wrM && (srcA == dstM)) valA = valM;
      else if (wrE && (srcA == dstE)) valA = valE;
      if (wrM && (srcB == dstM)) valB = valM;
      else if (wrE && (srcB == dstE)) valB = valE;
    end
  end

  assign rsp = regs[RSP_ID];

endmodule

// File: tb/tb_regfile_wb.sv
`timescale 1ns/10ps
// tb_regfile_wb: directed and randomized checks of regfile_wb against a
// behavioural model (array of registers, halt flag, integer write count).
module tb_regfile_wb;

  localparam int         W    = 64;
  localparam logic [W-1:0] RSPR = 64'h100;
  localparam logic [3:0] RN   = 4'hF;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         wb_en  = 1'b0;
  logic [1:0]   stat   = 2'd0;
  logic [3:0]   srcA   = 4'h0;
  logic [3:0]   srcB   = 4'h0;
  logic [3:0]   dstE   = RN;
  logic [3:0]   dstM   = RN;
  logic [W-1:0] valE   = '0;
  logic [W-1:0] valM   = '0;
  logic [3:0]   dbg_id = 4'h0;
  logic [W-1:0] valA, valB, dbgVal, rspOut;
  logic         haltedOut;
  logic [15:0]  wrCount;

  regfile_wb #(
    .WIDTH(W), .NREGS(15), .BYPASS(1'b1), .RSP_RESET(RSPR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .stat(stat),
    .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
    .valE(valE), .valM(valM), .valA(valA), .valB(valB),
    .dbg_id(dbg_id), .dbg_val(dbgVal), .rsp(rspOut),
    .halted(haltedOut), .wr_count(wrCount)
  );

  int total = 0;
  int bad   = 0;
  bit checkOn = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] model [16];
  bit           mHalted;
  int           mCount;
  int           nNew;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) model[i] = '0;
      model[4] = RSPR;
      mHalted  = 1'b0;
      mCount   = 0;
    end else if (wb_en && !mHalted) begin
      if (stat != 2'd0) begin
        mHalted = 1'b1;
      end else begin
        nNew = 0;
        if (dstE != RN) begin model[dstE] = valE; nNew++; end
        if (dstM != RN) begin model[dstM] = valM; if (dstM != dstE) nNew++; end
        mCount = (mCount + nNew > 65535) ? 65535 : mCount + nNew;
      end
    end
  end

  function automatic logic [W-1:0] expRead(input logic [3:0] id);
    bit live;
    live = rst_n && wb_en && !mHalted && (stat == 2'd0);
    if (id == RN) return '0;
    if (live && dstM == id) return valM;
    if (live && dstE == id) return valE;
    return model[id];
  endfunction

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge clk) begin
    if (checkOn) begin
      check("valA", valA, expRead(srcA));
      check("valB", valB, expRead(srcB));
      check("dbg_val", dbgVal, (dbg_id == RN) ? '0 : model[dbg_id]);
      check("rsp", rspOut, model[4]);
      check("halted", {{(W-1){1'b0}}, haltedOut}, {{(W-1){1'b0}}, mHalted});
      check("wr_count", {{(W-16){1'b0}}, wrCount}, W'(mCount));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setIn(input logic en, input logic [1:0] st, input logic [3:0] sa,
                       input logic [3:0] sb, input logic [3:0] de, input logic [3:0] dm,
                       input logic [W-1:0] ve, input logic [W-1:0] vm);
    wb_en = en; stat = st; srcA = sa; srcB = sb;
    dstE = de; dstM = dm; valE = ve; valM = vm;
  endtask

  // Called just after a rising edge: asserts reset mid-cycle and checks
  // every read path reflects the reset image with no clock edge.
  task automatic resetCheck();
    #1 rst_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      srcA = 4'(i); srcB = 4'(15 - i); dbg_id = 4'(i);
      #0.1;
      check("rst valA", valA, (i == 4) ? RSPR : '0);
      check("rst valB", valB, ((15 - i) == 4) ? RSPR : '0);
      check("rst dbg_val", dbgVal, (i == 4) ? RSPR : '0);
    end
    check("rst rsp", rspOut, RSPR);
    check("rst halted", {{(W-1){1'b0}}, haltedOut}, '0);
    check("rst wr_count", {{(W-16){1'b0}}, wrCount}, '0);
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 rst_n = 1'b0;
    step();
    step();
    rst_n   = 1'b1;
    checkOn = 1'b1;

    // write reg 3, then reset mid-operation
    setIn(1, 0, 3, 0, 3, RN, 64'h33, 0);
    #2 check("bypass r3", valA, 64'h33);
    step();
    dbg_id = 3;
    #1 check("r3 written", dbgVal, 64'h33);
    check("count 1", {{(W-16){1'b0}}, wrCount}, 64'd1);
    setIn(0, 0, 0, 0, RN, RN, 0, 0);
    resetCheck();

    // dual write with bypass
    setIn(1, 0, 2, 5, 2, 5, 64'h11, 64'h22);
    #2 check("dual bypass A", valA, 64'h11);
    check("dual bypass B", valB, 64'h22);
    step();
    dbg_id = 2;
    #1 check("dual r2", dbgVal, 64'h11);
    dbg_id = 5;
    #1 check("dual r5", dbgVal, 64'h22);
    check("dual count", {{(W-16){1'b0}}, wrCount}, 64'd2);

    // E/M conflict: M wins, one write
    setIn(1, 0, 7, 7, 7, 7, 64'hAA, 64'hBB);
    #2 check("conflict bypass", valA, 64'hBB);
    step();
    dbg_id = 7;
    #1 check("conflict r7", dbgVal, 64'hBB);
    check("conflict count", {{(W-16){1'b0}}, wrCount}, 64'd3);

    // stall
    setIn(0, 0, 1, 0, 1, RN, 64'h55, 0);
    #2 check("stall no bypass", valA, 64'h0);
    step();
    dbg_id = 1;
    #1 check("stall r1", dbgVal, 64'h0);
    check("stall count", {{(W-16){1'b0}}, wrCount}, 64'd3);

    // RNONE on both ports, and read of RNONE
    setIn(1, 0, RN, 2, RN, RN, 64'h66, 64'h77);
    #2 check("rnone valA", valA, 64'h0);
    check("rnone valB", valB, 64'h11);
    step();
    check("rnone count", {{(W-16){1'b0}}, wrCount}, 64'd3);

    // halt, then suppressed write
    setIn(1, 1, 3, 0, 3, RN, 64'h9, 0);
    #2 check("halt no bypass", valA, 64'h0);
    step();
    dbg_id = 3;
    #1 check("halt set", {{(W-1){1'b0}}, haltedOut}, 64'd1);
    check("halt r3", dbgVal, 64'h0);
    setIn(1, 0, 3, 0, 3, RN, 64'h9, 0);
    #1 check("halted no bypass", valA, 64'h0);
    step();
    #1 check("halted r3", dbgVal, 64'h0);
    check("halted count", {{(W-16){1'b0}}, wrCount}, 64'd3);
    setIn(0, 0, 0, 0, RN, RN, 0, 0);
    step();
    check("halt held", {{(W-1){1'b0}}, haltedOut}, 64'd1);
    resetCheck();

    // randomized traffic, with occasional resets
    for (int c = 0; c < 600; c++) begin
      if (c % 150 == 149) begin
        resetCheck();
      end else begin
        setIn($urandom_range(0, 4) != 0,
              ($urandom_range(0, 59) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              {$urandom, $urandom}, {$urandom, $urandom});
        dbg_id = 4'($urandom_range(0, 15));
        step();
      end
    end

    // saturation: 32767 dual writes reach 0xFFFE
    setIn(0, 0, 0, 0, RN, RN, 0, 0);
    resetCheck();
    for (int k = 0; k < 32767; k++) begin
      setIn(1, 0, 0, 1, 0, 1, {$urandom, $urandom}, {$urandom, $urandom});
      step();
    end
    check("sat pre", {{(W-16){1'b0}}, wrCount}, 64'hFFFE);
    step();
    check("sat hit", {{(W-16){1'b0}}, wrCount}, 64'hFFFF);
    step();
    step();
    check("sat hold", {{(W-16){1'b0}}, wrCount}, 64'hFFFF);

    setIn(0, 0, 0, 0, RN, RN, 0, 0);
    step();
    checkOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
